// File: rtl/mlp_pkg.sv
// Shared types and defaults for the MLP layer sequencer.
// States, default widths and address-width helper.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } state_t;

  localparam int A_WIDTH_D   = 8;
  localparam int B_WIDTH_D   = 8;
  localparam int ACC_WIDTH_D = 32;
  localparam int N_IN_D      = 4;
  localparam int N_OUT_D     = 3;

  function automatic int addr_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mlp_sat_act.sv
// Accumulator to activation-width saturation with optional ReLU.
// Build with MLP_SEQ_RELU_EN to clamp negative outputs to zero.
module mlp_sat_act
  import mlp_pkg::*;
#(
  parameter int A_WIDTH   = A_WIDTH_D,
  parameter int ACC_WIDTH = ACC_WIDTH_D
) (
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [A_WIDTH-1:0]   y
);

  localparam logic signed [ACC_WIDTH-1:0] HI =
    {{(ACC_WIDTH-A_WIDTH+1){1'b0}}, {(A_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] LO = ~HI;

  logic [A_WIDTH-1:0] sat;

  always_comb begin
    sat = acc[A_WIDTH-1:0];
    unique case (1'b1)
      ($signed(acc) > HI): sat = {1'b0, {(A_WIDTH-1){1'b1}}};
      ($signed(acc) < LO): sat = {1'b1, {(A_WIDTH-1){1'b0}}};
      default:             sat = acc[A_WIDTH-1:0];
    endcase
  end

  always_comb begin
    y = sat;
`ifdef MLP_SEQ_RELU_EN
    if (sat[A_WIDTH-1]) y = '0;
`else
    y = sat;
`endif
  end

endmodule

// File: rtl/mlp_mac_sequencer.sv
// Fully-connected layer sequencer driving a MAC start/valid port.
// Optional ReLU output stage: define MLP_SEQ_RELU_EN.
module mlp_mac_sequencer
  import mlp_pkg::*;
#(
  parameter int A_WIDTH   = A_WIDTH_D,
  parameter int B_WIDTH   = B_WIDTH_D,
  parameter int ACC_WIDTH = ACC_WIDTH_D,
  parameter int N_IN      = N_IN_D,
  parameter int N_OUT     = N_OUT_D,
  localparam int XA_W = addr_w(N_IN),
  localparam int WA_W = addr_w(N_IN * N_OUT),
  localparam int YA_W = addr_w(N_OUT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [XA_W-1:0]      x_addr,
  input  logic [A_WIDTH-1:0]   x_rdata,
  output logic [WA_W-1:0]      w_addr,
  input  logic [B_WIDTH-1:0]   w_rdata,
  output logic                 mac_start,
  output logic                 mac_valid,
  output logic [A_WIDTH-1:0]   mac_a,
  output logic [B_WIDTH-1:0]   mac_b,
  input  logic [ACC_WIDTH-1:0] mac_result,
  output logic                 y_we,
  output logic [YA_W-1:0]      y_addr,
  output logic [A_WIDTH-1:0]   y_wdata
);

  localparam logic [XA_W-1:0] I_LAST = XA_W'(N_IN - 1);
  localparam logic [YA_W-1:0] J_LAST = YA_W'(N_OUT - 1);

  state_t state;
  state_t state_nxt;

  logic [XA_W-1:0]    i_q;
  logic [YA_W-1:0]    j_q;
  logic [WA_W-1:0]    w_q;
  logic               rd_vld;
  logic               rd_first;
  logic [A_WIDTH-1:0] act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    y_we      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        if (i_q == I_LAST) state_nxt = WAIT;
      end
      WAIT: begin
        busy      = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        y_we      = 1'b1;
        state_nxt = (j_q == J_LAST) ? DONE : ISSUE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Weight address walks linearly, so j*N_IN+i is just a running count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q      <= '0;
      j_q      <= '0;
      w_q      <= '0;
      rd_vld   <= 1'b0;
      rd_first <= 1'b0;
    end else begin
      rd_vld   <= (state == ISSUE);
      rd_first <= (state == ISSUE) && (i_q == '0);
      unique case (state)
        IDLE: begin
          if (start) begin
            i_q <= '0;
            j_q <= '0;
            w_q <= '0;
          end
        end
        ISSUE: begin
          if (i_q != I_LAST) begin
            i_q <= i_q + 1'b1;
            w_q <= w_q + 1'b1;
          end
        end
        WRITE: begin
          if (j_q != J_LAST) begin
            j_q <= j_q + 1'b1;
            i_q <= '0;
            w_q <= w_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  mlp_sat_act #(
    .A_WIDTH   (A_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat (
    .acc (mac_result),
    .y   (act)
  );

  assign x_addr    = i_q;
  assign w_addr    = w_q;
  assign y_addr    = j_q;
  assign y_wdata   = y_we ? act : '0;
  assign mac_start = rd_vld & rd_first;
  assign mac_valid = rd_vld & ~rd_first;
  assign mac_a     = x_rdata;
  assign mac_b     = w_rdata;

endmodule

// File: tb/tb_mlp_mac_sequencer.sv
// Directed bench for mlp_mac_sequencer with RAM and MAC models.
module tb_mlp_mac_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start1, start2, sel, ovr;
  logic signed [31:0] ovr_val;

  logic        busy1, done1, ms1, mv1, we1;
  logic [1:0]  xa1, ya1;
  logic [3:0]  wa1;
  logic [7:0]  xd1, wd1, a1, b1, yd1;
  logic [31:0] res1;
  logic signed [31:0] acc1;

  logic        busy2, done2, ms2, mv2, we2;
  logic [0:0]  xa2, wa2, ya2;
  logic [7:0]  xd2, wd2, a2, b2, yd2;
  logic [31:0] res2;
  logic signed [31:0] acc2;

  logic [7:0] xm1 [4];
  logic [7:0] wm1 [12];
  logic [7:0] xm2 [2];
  logic [7:0] wm2 [2];

  mlp_mac_sequencer dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .busy(busy1), .done(done1),
    .x_addr(xa1), .x_rdata(xd1),
    .w_addr(wa1), .w_rdata(wd1),
    .mac_start(ms1), .mac_valid(mv1),
    .mac_a(a1), .mac_b(b1), .mac_result(res1),
    .y_we(we1), .y_addr(ya1), .y_wdata(yd1)
  );

  mlp_mac_sequencer #(.N_IN(1), .N_OUT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .busy(busy2), .done(done2),
    .x_addr(xa2), .x_rdata(xd2),
    .w_addr(wa2), .w_rdata(wd2),
    .mac_start(ms2), .mac_valid(mv2),
    .mac_a(a2), .mac_b(b2), .mac_result(res2),
    .y_we(we2), .y_addr(ya2), .y_wdata(yd2)
  );

  always @(posedge clk) begin
    xd1 <= xm1[xa1];
    wd1 <= wm1[wa1];
    xd2 <= xm2[xa2];
    wd2 <= wm2[wa2];
    if (ms1)      acc1 <= $signed(a1) * $signed(b1);
    else if (mv1) acc1 <= acc1 + $signed(a1) * $signed(b1);
    if (ms2)      acc2 <= $signed(a2) * $signed(b2);
    else if (mv2) acc2 <= acc2 + $signed(a2) * $signed(b2);
  end

  assign res1 = ovr ? ovr_val : acc1;
  assign res2 = acc2;

  logic o_busy, o_done, o_ms, o_mv, o_we;
  int   o_xa, o_wa, o_ya, o_yd;
  always_comb begin
    o_busy = sel ? busy2 : busy1;
    o_done = sel ? done2 : done1;
    o_ms   = sel ? ms2 : ms1;
    o_mv   = sel ? mv2 : mv1;
    o_we   = sel ? we2 : we1;
    o_xa   = sel ? int'(xa2) : int'(xa1);
    o_wa   = sel ? int'(wa2) : int'(wa1);
    o_ya   = sel ? int'(ya2) : int'(ya1);
    o_yd   = sel ? int'($signed(yd2)) : int'($signed(yd1));
  end

  int npass = 0;
  int ntot  = 0;

  int ms_q[$], mv_q[$], we_q[$], ya_q[$], yd_q[$];
  int xa_a[64], wa_a[64];
  int done_c, busy1c, busyd, ovl;

  task automatic chk(input string tag, input int obs, input int exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int act(input int v);
`ifdef MLP_SEQ_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic run(input bit rep);
    ms_q.delete(); mv_q.delete(); we_q.delete();
    ya_q.delete(); yd_q.delete();
    done_c = 0; busy1c = 0; busyd = 1; ovl = 0;
    @(posedge clk); #1;
    if (sel) start2 = 1'b1;
    else     start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (o_ms) ms_q.push_back(c);
      if (o_mv) mv_q.push_back(c);
      if (o_ms && o_mv) ovl = 1;
      if (o_we) begin
        we_q.push_back(c);
        ya_q.push_back(o_ya);
        yd_q.push_back(o_yd);
      end
      xa_a[c] = o_xa;
      wa_a[c] = o_wa;
      if (c == 1) busy1c = int'(o_busy);
      if (o_done) begin
        done_c = c;
        busyd  = int'(o_busy);
        break;
      end
      @(posedge clk); #1;
      start1 = rep && (c == 4);
    end
  endtask

  task automatic check_std(input string t);
    chk({t, "_busy_c1"}, busy1c, 1);
    chk({t, "_ms_n"}, ms_q.size(), 3);
    chk({t, "_ms_c0"}, ms_q[0], 2);
    chk({t, "_ms_c2"}, ms_q[2], 14);
    chk({t, "_mv_n"}, mv_q.size(), 9);
    chk({t, "_mv_c0"}, mv_q[0], 3);
    chk({t, "_overlap"}, ovl, 0);
    chk({t, "_we_n"}, we_q.size(), 3);
    chk({t, "_we_c0"}, we_q[0], 6);
    chk({t, "_we_c2"}, we_q[2], 18);
    chk({t, "_y0"}, yd_q[0], 10);
    chk({t, "_y1"}, yd_q[1], 5);
    chk({t, "_y2"}, yd_q[2], 13);
    chk({t, "_yaddr2"}, ya_q[2], 2);
    chk({t, "_waddr_c7"}, wa_a[7], 4);
    chk({t, "_waddr_c16"}, wa_a[16], 11);
    chk({t, "_xaddr_c16"}, xa_a[16], 3);
    chk({t, "_done_c"}, done_c, 19);
    chk({t, "_busy_done"}, busyd, 0);
  endtask

  int ov_in[6]  = '{300, -300, 127, -128, -129, 128};
  int ov_exp[6] = '{127, -128, 127, -128, -128, 127};
  int any_we;

  initial begin
    xm1 = '{8'd1, 8'd2, 8'd3, 8'd4};
    wm1 = '{8'd1, 8'd1, 8'd1, 8'd1,
            8'd1, -8'sd1, 8'd2, 8'd0,
            -8'sd2, 8'd0, 8'd1, 8'd3};
    xm2 = '{8'd5, 8'd0};
    wm2 = '{8'd3, -8'sd2};
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
    sel = 1'b0; ovr = 1'b0; ovr_val = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_ms", int'(ms1), 0);
    chk("rst_mv", int'(mv1), 0);
    chk("rst_we", int'(we1), 0);
    chk("rst_xaddr", int'(xa1), 0);
    chk("rst_waddr", int'(wa1), 0);
    chk("rst_yaddr", int'(ya1), 0);
    chk("rst_ywdata", int'(yd1), 0);
    @(negedge clk) rst_n = 1'b1;

    run(1'b0);
    check_std("basic");

    run(1'b1);
    check_std("restart");

    ovr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ovr_val = ov_in[k];
      run(1'b0);
      chk($sformatf("sat_n_%0d", ov_in[k]), we_q.size(), 3);
      chk($sformatf("sat_%0d", ov_in[k]), yd_q[0], act(ov_exp[k]));
    end
    ovr = 1'b0;

    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_mv", int'(mv1), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy1), 0);
    chk("mid_rst_mv", int'(mv1), 0);
    chk("mid_rst_ms", int'(ms1), 0);
    chk("mid_rst_xaddr", int'(xa1), 0);
    chk("mid_rst_waddr", int'(wa1), 0);
    any_we = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (we1 || done1 || mv1 || ms1) any_we = 1;
    end
    chk("mid_rst_quiet", any_we, 0);
    @(negedge clk) rst_n = 1'b1;
    run(1'b0);
    check_std("post_rst");

    run(1'b0);
    check_std("b2b_a");
    run(1'b0);
    check_std("b2b_b");

    sel = 1'b1;
    run(1'b0);
    chk("n1_ms_n", ms_q.size(), 2);
    chk("n1_ms_c0", ms_q[0], 2);
    chk("n1_ms_c1", ms_q[1], 5);
    chk("n1_mv_n", mv_q.size(), 0);
    chk("n1_we_n", we_q.size(), 2);
    chk("n1_we_c0", we_q[0], 3);
    chk("n1_we_c1", we_q[1], 6);
    chk("n1_y0", yd_q[0], 15);
    chk("n1_y1", yd_q[1], act(-10));
    chk("n1_yaddr1", ya_q[1], 1);
    chk("n1_done_c", done_c, 7);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/mlp_mac_sequencer.md
Name: mlp_mac_sequencer

Overview:
- Initiator side of the MAC start/valid interface; computes one fully-connected layer.
- Fetches inputs x[i] and weights w[j][i] from synchronous RAMs and drives the MAC with start on the first product and valid on each later one.
- Captures the MAC result per neuron, saturates it to A_WIDTH and writes y[j] to the output RAM. Sits between the layer memories and the MAC in the MLP IP.

Parameters:
- A_WIDTH, 8, width of x, y and MAC input a (signed).
- B_WIDTH, 8, width of weights and MAC input b (signed).
- ACC_WIDTH, 32, width of MAC result (signed).
- N_IN, 4, inputs per neuron (>=1).
- N_OUT, 3, neurons in the layer (>=1).
- Derived localparams: XA_W=clog2(N_IN), WA_W=clog2(N_IN*N_OUT), YA_W=clog2(N_OUT), each at least 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle layer-run request
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle pulse after the last write
- x_addr  out  XA_W  input RAM address
- x_rdata  in  A_WIDTH  input RAM data, 1-cycle latency
- w_addr  out  WA_W  weight RAM address, value j*N_IN+i
- w_rdata  in  B_WIDTH  weight RAM data, 1-cycle latency
- mac_start  out  1  MAC initialise strobe (acc = a*b)
- mac_valid  out  1  MAC accumulate strobe (acc += a*b)
- mac_a  out  A_WIDTH  equals x_rdata
- mac_b  out  B_WIDTH  equals w_rdata
- mac_result  in  ACC_WIDTH  MAC output, valid the cycle after the last strobe
- y_we  out  1  output RAM write enable
- y_addr  out  YA_W  output RAM address
- y_wdata  out  A_WIDTH  saturated neuron output

Behaviour:
- Reset values: busy, done, mac_start, mac_valid, y_we = 0. All addresses, y_wdata and counters = 0. State = IDLE.
- FSM states: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE: start=1 at edge 0 loads i=0, j=0 and moves to ISSUE. busy=1 from cycle 1. start while busy is ignored.
- ISSUE (N_IN cycles): x_addr=i, w_addr=j*N_IN+i are registered outputs; i increments each cycle. After i=N_IN-1 the FSM goes to WAIT.
- Read tracking: a 2-bit pipe (rd_vld, rd_first) runs one cycle behind the address issue.
  - mac_start = rd_vld & rd_first
  - mac_valid = rd_vld & ~rd_first
  - mac_start and mac_valid are never high together.
- WAIT (1 cycle): the last data beat is presented to the MAC.
- WRITE (1 cycle): y_we=1, y_addr=j, y_wdata=sat(mac_result). Then either j++ and back to ISSUE, or DONE if j=N_OUT-1.
- DONE (1 cycle): done=1, busy drops in the same cycle, then IDLE.
- Latency: N_IN+2 cycles per neuron; done lands in cycle N_OUT*(N_IN+2)+1 after the start edge.
- Saturation: mac_result > 2^(A_WIDTH-1)-1 gives the maximum; < -2^(A_WIDTH-1) gives the minimum; otherwise the low A_WIDTH bits.
- N_IN=1: each neuron gets only mac_start, never mac_valid.
- Reset mid-run: immediate return to IDLE with no further strobes or writes. The MAC accumulator is not cleared, because the next mac_start reinitialises it.
- mac_a and mac_b pass RAM data straight through, with no register.

Optional Feature:
- Macro: MLP_SEQ_RELU_EN.
- Defined: ReLU is applied after saturation, so negative results are written as 0.
- Undefined: the signed saturated value is written unchanged.

Decomposition:
- Package mlp_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/WRITE/DONE)
  - default width constants
  - a clog2-based address-width helper
- One natural sub-module: mlp_sat_act. It is combinational: ACC_WIDTH to A_WIDTH saturation plus the optional ReLU.

Test Plan:
- x={1,2,3,4}, w row0={1,1,1,1} and the MAC model computes the plain sum. Expect mac_start in cycle 2, mac_valid in cycles 3–5, y_we in cycle 6 with y[0]=10, done in cycle 19.
- mac_result forced to 300 / -300. Expect y_wdata=127 / -128. With MLP_SEQ_RELU_EN, -300 gives 0.
- N_IN=1, N_OUT=2. Expect only mac_start pulses (cycles 2 and 5), never mac_valid; writes in cycles 3 and 6; done in cycle 7.
- start re-pulsed in cycle 5 of a run. Expect no effect on the address sequence, write count or done timing.
- rst_n low in cycle 4. Expect outputs 0 immediately with no y_we. A fresh start then produces a correct full layer.
- Back-to-back runs with start on the cycle after done. Expect identical outputs and cycle timing.
